// File: rtl/branch_cond_unit.sv
// ---------------------------------------------------------------------------
// BranchCondUnit: resolves one conditional branch at a time against a latched
// copy of the ALU status flags, and returns the taken flag plus the next PC.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset
//   flag_we      load flag_in into the status register (any state)
//   flag_in      {overflow, negative, zero} from the ALU
//   alu_busy     a flag-producing ALU op is still in flight
//   br_req       branch request (accepted only while br_ready=1)
//   br_cond      condition code
//   br_offset    signed two's-complement PC offset
//   pc_in        PC of the branch instruction
//   br_ack       consumer accepts the current result
//   br_ready     block is idle and can take a request
//   br_valid     result on br_taken/br_target is valid
//   br_taken     branch resolved taken
//   br_target    resolved next PC
//   status_q     latched flags {V,N,Z}
//   taken_count  saturating count of taken branches
// ---------------------------------------------------------------------------
module branch_cond_unit #(
  parameter int width = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flag_we,
  input  logic [2:0]       flag_in,
  input  logic             alu_busy,
  input  logic             br_req,
  input  logic [2:0]       br_cond,
  input  logic [width-1:0] br_offset,
  input  logic [width-1:0] pc_in,
  input  logic             br_ack,
  output logic             br_ready,
  output logic             br_valid,
  output logic             br_taken,
  output logic [width-1:0] br_target,
  output logic [2:0]       status_q,
  output logic [7:0]       taken_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [2:0]       r_status;
  logic [2:0]       r_cond;
  logic [width-1:0] r_offset;
  logic [width-1:0] r_pc;
  logic             r_taken;
  logic [width-1:0] r_target;
  logic [7:0]       r_count;

  logic             w_condMet;
  logic [width-1:0] w_seqPc;
  logic [width-1:0] w_branchPc;

  // Status flags are written whenever the ALU says so, independent of the
  // branch FSM, so a branch always sees the most recent completed result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_status <= 3'b000;
    end else if (flag_we) begin
      r_status <= flag_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Request fields are captured once in IDLE so the requester may change
  // its inputs freely while the branch is waiting or being evaluated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cond   <= 3'b000;
      r_offset <= '0;
      r_pc     <= '0;
    end else if (r_state == IDLE && br_req) begin
      r_cond   <= br_cond;
      r_offset <= br_offset;
      r_pc     <= pc_in;
    end
  end

  // Condition decode against the status register as it stands during EVAL;
  // a flag write on the EVAL->RESP edge lands too late to be seen here.
  always_comb begin
    w_condMet = 1'b0;
    case (r_cond)
      3'b000:  w_condMet = 1'b1;
      3'b001:  w_condMet = r_status[0];
      3'b010:  w_condMet = ~r_status[0];
      3'b011:  w_condMet = r_status[1] ^ r_status[2];
      3'b100:  w_condMet = ~(r_status[1] ^ r_status[2]);
      3'b101:  w_condMet = r_status[1];
      3'b110:  w_condMet = r_status[2];
      default: w_condMet = 1'b0;
    endcase
  end

  // Offset already has the full PC width, so sign extension is implicit and
  // the plain sum wraps modulo 2^width.
  assign w_seqPc    = r_pc + width'(1);
  assign w_branchPc = w_seqPc + r_offset;

  // Result and statistics are registered on the EVAL->RESP edge and then
  // held untouched through RESP until the consumer acknowledges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_taken  <= 1'b0;
      r_target <= '0;
      r_count  <= 8'd0;
    end else if (r_state == EVAL) begin
      r_taken  <= w_condMet;
      r_target <= w_condMet ? w_branchPc : w_seqPc;
      if (w_condMet && r_count != 8'hFF) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (br_req) begin
          w_nextState = alu_busy ? WAIT : EVAL;
        end
      end
      WAIT: begin
        if (!alu_busy) begin
          w_nextState = EVAL;
        end
      end
      EVAL: begin
        w_nextState = RESP;
      end
      RESP: begin
        if (br_ack) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign br_ready    = (r_state == IDLE);
  assign br_valid    = (r_state == RESP);
  assign br_taken    = r_taken;
  assign br_target   = r_target;
  assign status_q    = r_status;
  assign taken_count = r_count;

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL expose parameter: width, 16, data/PC width in bits.
REQ-003 Port: clock  in  1  system clock, rising-edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: flag_we  in  1  load flag_in into the status register.
REQ-006 Port: flag_in  in  3  {overflow, negative, zero} from ALU status logic.
REQ-007 Port: alu_busy  in  1  flag-producing ALU op in flight; flags not yet final.
REQ-008 Port: br_req  in  1  branch request valid.
REQ-009 Port: br_cond  in  3  condition code.
REQ-010 Port: br_offset  in  width  signed two's-complement PC offset.
REQ-011 Port: pc_in  in  width  PC of the branch instruction.
REQ-012 Port: br_ack  in  1  consumer accepts result.
REQ-013 Port: br_ready  out  1  block can accept br_req.
REQ-014 Port: br_valid  out  1  result valid.
REQ-015 Port: br_taken  out  1  branch resolved taken.
REQ-016 Port: br_target  out  width  resolved next PC.
REQ-017 Port: status_q  out  3  latched flags {V,N,Z}.
REQ-018 Port: taken_count  out  8  saturating count of taken branches.

Function
REQ-019 status_q SHALL load flag_in on each rising clock edge with flag_we=1, in every FSM state.
REQ-020 FSM states SHALL be IDLE, WAIT, EVAL, RESP; br_ready=1 only in IDLE; br_valid=1 only in RESP.
REQ-021 IDLE: br_req=1 SHALL capture br_cond, br_offset, pc_in and go to WAIT if alu_busy=1, else EVAL; br_req=0 stays IDLE.
REQ-022 WAIT SHALL hold until a cycle with alu_busy=0, then go to EVAL.
REQ-023 EVAL SHALL evaluate the condition against status_q as held during the EVAL cycle (a flag_we at the end of EVAL is not seen), register br_taken/br_target, and go to RESP.
REQ-024 Conditions SHALL be: 000 always; 001 EQ (Z); 010 NE (!Z); 011 LT (N xor V); 100 GE (!(N xor V)); 101 MI (N); 110 VS (V); 111 never.
REQ-025 Taken: br_target = pc + 1 + sign-extended offset, modulo 2^width (wraps). Not taken: pc + 1, modulo 2^width.
REQ-026 RESP SHALL hold br_valid, br_taken, br_target stable until br_ack=1, then return to IDLE on that edge.
REQ-027 br_req in any state other than IDLE SHALL be ignored.
REQ-028 Hazard-free latency SHALL be: request edge N, EVAL during cycle N+1, br_valid=1 from edge N+2.
REQ-029 taken_count SHALL increment by 1 on the EVAL-to-RESP edge when taken, saturating at 255.
REQ-030 br_ack outside RESP SHALL have no effect.

Reset
REQ-031 Reset SHALL immediately force state=IDLE, status_q=000, br_valid=0, br_taken=0, br_target=0, taken_count=0, captured fields=0.
REQ-032 Reset asserted mid-transaction (WAIT/EVAL/RESP) SHALL abort it with no result delivered.
REQ-033 After reset release, br_ready SHALL be 1 in the first cycle.

Verification
REQ-034 flag_we=1, flag_in=001; then br_req with cond=001, pc=0x0010, offset=0x0005, alu_busy=0 -> br_valid at request edge+2, br_taken=1, br_target=0x0016, taken_count=1.
REQ-035 status_q=000; br_req with cond=001, pc=0x0010 -> br_taken=0, br_target=0x0011.
REQ-036 br_req with alu_busy=1 for 3 cycles, flag_we writes 010 while busy, cond=101 -> stays in WAIT, then taken; br_valid 2 cycles after alu_busy falls.
REQ-037 Wrap-around: pc=0xFFFF, offset=0x0000, cond=000 -> target 0x0000; pc=0x0010, offset=0xFFFE -> target 0x000F.
REQ-038 Hold br_ack=0 for 5 cycles in RESP with a new br_req -> outputs stable, br_ready=0, request ignored; 260 always-taken branches -> taken_count=255.
REQ-039 Assert reset during WAIT and during RESP -> all outputs zero immediately, br_ready=1 after release.
